// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle CPU. It sequences fetch, decode, execute,
// memory and write-back, drives every datapath strobe, and counts retired instructions.
module multi_cycle_ctrl #(
    parameter int         CNT_W   = 16,
    parameter logic [5:0] HALT_OP = 6'h3F
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic             ExtOp,
    output logic [1:0]       AluCtrl,
    output logic             Halted,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrRetired
);

    typedef enum logic [3:0] {
        IF_S    = 4'd0,
        ID_S    = 4'd1,
        EX_R    = 4'd2,
        WB_R    = 4'd3,
        EX_I    = 4'd4,
        WB_I    = 4'd5,
        MEM_ADR = 4'd6,
        MEM_RD  = 4'd7,
        WB_LW   = 4'd8,
        MEM_WR  = 4'd9,
        BR_S    = 4'd10,
        JMP_S   = 4'd11,
        HALT_S  = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              isAddu, isSubu, retiring;

    assign isAddu = (Opcode == OP_RTYPE) && (Funct == FN_ADDU);
    assign isSubu = (Opcode == OP_RTYPE) && (Funct == FN_SUBU);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IF_S;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Opcode and Funct come from the IR, so they stay stable from ID until the
    // instruction completes and can be consulted again in MEM_ADR.
    always_comb begin
        state_d = IF_S;
        case (state_q)
            IF_S:    state_d = ID_S;
            ID_S: begin
                if (isAddu || isSubu)                         state_d = EX_R;
                else if (Opcode == OP_ORI)                    state_d = EX_I;
                else if (Opcode == OP_LW || Opcode == OP_SW)  state_d = MEM_ADR;
                else if (Opcode == OP_BEQ)                    state_d = BR_S;
                else if (Opcode == OP_J)                      state_d = JMP_S;
                else if (Opcode == HALT_OP)                   state_d = HALT_S;
                else                                          state_d = IF_S;
            end
            EX_R:    state_d = WB_R;
            EX_I:    state_d = WB_I;
            MEM_ADR: state_d = (Opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:  state_d = WB_LW;
            HALT_S:  state_d = HALT_S;
            default: state_d = IF_S;
        endcase
    end

    assign retiring = (state_q == WB_R) || (state_q == WB_I) || (state_q == WB_LW) ||
                      (state_q == MEM_WR) || (state_q == BR_S) || (state_q == JMP_S);
    assign cnt_d    = retiring ? cnt_q + CNT_W'(1) : cnt_q;

    // Strobes are gated by Rst_n so that an abandoned instruction emits nothing
    // while reset is held, even though the state register already reads IF.
    always_comb begin
        PCWrite  = 1'b0;
        PCSrc    = 2'b00;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        AluSrcA  = 1'b0;
        AluSrcB  = 2'b00;
        ExtOp    = 1'b0;
        AluCtrl  = 2'b00;
        Halted   = 1'b0;
        if (Rst_n) begin
            case (state_q)
                IF_S: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    AluSrcB = 2'b01;
                    PCWrite = 1'b1;
                end
                ID_S: begin
                    AluSrcB = 2'b11;
                    ExtOp   = 1'b1;
                end
                EX_R: begin
                    AluSrcA = 1'b1;
                    AluCtrl = isSubu ? 2'b01 : 2'b00;
                end
                WB_R: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                EX_I: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b10;
                    AluCtrl = 2'b10;
                end
                WB_I:    RegWrite = 1'b1;
                MEM_ADR: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b10;
                    ExtOp   = 1'b1;
                end
                MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                WB_LW: begin
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                end
                MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                BR_S: begin
                    AluSrcA = 1'b1;
                    AluCtrl = 2'b01;
                    PCSrc   = 2'b01;
                    PCWrite = Zero;
                end
                JMP_S: begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                end
                HALT_S:  Halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign State        = state_q;
    assign InstrRetired = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized self-checking bench for multi_cycle_ctrl, compared per cycle against an
// instruction-level model of state walk, control strobes and retired count.
module tb_multi_cycle_ctrl;

    localparam int CNT_W = 4;

    logic             Clk, Rst_n, Zero;
    logic [5:0]       Opcode, Funct;
    logic             PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg;
    logic             RegWrite, AluSrcA, ExtOp, Halted;
    logic [1:0]       PCSrc, AluSrcB, AluCtrl;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrRetired;

    int testsRun  = 0;
    int failCount = 0;
    int modelCnt  = 0;
    int expSeq[$];

    multi_cycle_ctrl #(.CNT_W(CNT_W), .HALT_OP(6'h3F)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .ExtOp(ExtOp),
        .AluCtrl(AluCtrl), .Halted(Halted), .State(State), .InstrRetired(InstrRetired)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    wire [16:0] ctrlVec = {PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst,
                           MemToReg, RegWrite, AluSrcA, AluSrcB, ExtOp, AluCtrl, Halted};

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Instruction classes: 0 R-type, 1 ori, 2 lw, 3 sw, 4 beq, 5 j, 6 nop, 7 halt
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h21 || fn == 6'h23) ? 0 : 6;
        case (op)
            6'h0D:   return 1;
            6'h23:   return 2;
            6'h2B:   return 3;
            6'h04:   return 4;
            6'h02:   return 5;
            6'h3F:   return 7;
            default: return 6;
        endcase
    endfunction

    function automatic logic [16:0] expCtrl(input int st, input logic z, input logic [5:0] fn);
        logic pcw = 0, iord = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0;
        logic asa = 0, ext = 0, hlt = 0;
        logic [1:0] pcs = 0, asb = 0, alu = 0;
        case (st)
            0:  begin mr = 1; irw = 1; asb = 2'b01; pcw = 1; end
            1:  begin asb = 2'b11; ext = 1; end
            2:  begin asa = 1; alu = (fn == 6'h23) ? 2'b01 : 2'b00; end
            3:  begin rd = 1; rw = 1; end
            4:  begin asa = 1; asb = 2'b10; alu = 2'b10; end
            5:  rw = 1;
            6:  begin asa = 1; asb = 2'b10; ext = 1; end
            7:  begin mr = 1; iord = 1; end
            8:  begin m2r = 1; rw = 1; end
            9:  begin mw = 1; iord = 1; end
            10: begin asa = 1; alu = 2'b01; pcs = 2'b01; pcw = z; end
            11: begin pcs = 2'b10; pcw = 1; end
            12: hlt = 1;
            default: ;
        endcase
        return {pcw, pcs, iord, mr, mw, irw, rd, m2r, rw, asa, asb, ext, alu, hlt};
    endfunction

    // Runs one instruction from IF; expects to start at negedge+1 with State=IF.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int kind = classify(op, fn);
        Opcode = op; Funct = fn; Zero = z;
        expSeq = {0, 1};
        case (kind)
            0: expSeq = {expSeq, 2, 3};
            1: expSeq = {expSeq, 4, 5};
            2: expSeq = {expSeq, 6, 7, 8};
            3: expSeq = {expSeq, 6, 9};
            4: expSeq = {expSeq, 10};
            5: expSeq = {expSeq, 11};
            7: for (int i = 0; i < 20; i++) expSeq.push_back(12);
            default: ;
        endcase
        #1;
        for (int i = 0; i < expSeq.size(); i++) begin
            checkOutput("state", 32'(State), 32'(expSeq[i]));
            checkOutput("ctrl", 32'(ctrlVec), 32'(expCtrl(expSeq[i], z, fn)));
            checkOutput("retired", 32'(InstrRetired), 32'(modelCnt));
            @(posedge Clk);
            if (i == expSeq.size() - 1 && kind != 6 && kind != 7)
                modelCnt = (modelCnt + 1) % (1 << CNT_W);
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_state"}, 32'(State), 32'd0);
        checkOutput({tag, "_ctrl"}, 32'(ctrlVec), 32'd0);
        checkOutput({tag, "_retired"}, 32'(InstrRetired), 32'd0);
    endtask

    logic [5:0] rOp, rFn;

    initial begin
        Rst_n = 1'b0; Opcode = '0; Funct = '0; Zero = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        checkReset("reset");
        Rst_n = 1'b1;

        applyStimulus(6'h00, 6'h21, 1'b0);
        applyStimulus(6'h00, 6'h23, 1'b1);
        applyStimulus(6'h0D, 6'h15, 1'b0);
        applyStimulus(6'h23, 6'h00, 1'b0);
        applyStimulus(6'h2B, 6'h07, 1'b1);
        applyStimulus(6'h04, 6'h00, 1'b1);
        applyStimulus(6'h04, 6'h00, 1'b0);
        applyStimulus(6'h3E, 6'h21, 1'b0);
        applyStimulus(6'h00, 6'h00, 1'b0);

        // Abandon a lw in MEM_RD with an asynchronous reset mid low phase.
        Opcode = 6'h23; Funct = 6'h00; Zero = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        checkOutput("pre_reset_state", 32'(State), 32'd7);
        #2 Rst_n = 1'b0;
        #1;
        modelCnt = 0;
        checkReset("mid_reset");
        @(negedge Clk);
        #1 Rst_n = 1'b1;

        for (int i = 0; i < 16; i++) applyStimulus(6'h02, $urandom_range(0, 63), $urandom_range(0, 1));
        checkOutput("wrap", 32'(InstrRetired), 32'd0);

        for (int n = 0; n < 300; n++) begin
            rFn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 8))
                0: begin rOp = 6'h00; rFn = 6'h21; end
                1: begin rOp = 6'h00; rFn = 6'h23; end
                2: rOp = 6'h0D;
                3: rOp = 6'h23;
                4: rOp = 6'h2B;
                5: rOp = 6'h04;
                6: rOp = 6'h02;
                7: begin
                    rOp = 6'h00;
                    while (rFn == 6'h21 || rFn == 6'h23) rFn = 6'($urandom_range(0, 63));
                end
                default: begin
                    rOp = 6'($urandom_range(1, 62));
                    while (rOp == 6'h0D || rOp == 6'h23 || rOp == 6'h2B || rOp == 6'h04 || rOp == 6'h02)
                        rOp = 6'($urandom_range(1, 62));
                end
            endcase
            applyStimulus(rOp, rFn, 1'($urandom_range(0, 1)));
        end

        applyStimulus(6'h3F, 6'h00, 1'b1);
        checkOutput("halt_hold", 32'(Halted), 32'd1);

        #2 Rst_n = 1'b0;
        #1;
        modelCnt = 0;
        checkReset("halt_reset");
        @(negedge Clk);
        #1 Rst_n = 1'b1;
        applyStimulus(6'h00, 6'h21, 1'b0);
        checkOutput("after_halt", 32'(InstrRetired), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
